// File: rtl/wb_cmd_initiator_if.sv
// Command, response and Wishbone pipelined-mode bus bundle for wb_cmd_initiator.
interface wb_cmd_initiator_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic                  cmd_we_i;
  logic [ADDR_WIDTH-1:0] cmd_adr_i;
  logic [31:0]           cmd_dat_i;
  logic [3:0]            cmd_sel_i;

  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [31:0]           rsp_dat_o;
  logic [1:0]            rsp_status_o;

  logic                  wb_cyc_o;
  logic                  wb_stb_o;
  logic                  wb_we_o;
  logic [ADDR_WIDTH-1:0] wb_adr_o;
  logic [3:0]            wb_sel_o;
  logic [31:0]           wb_dat_o;
  logic                  wb_ack_i;
  logic                  wb_err_i;
  logic                  wb_rty_i;
  logic                  wb_stall_i;
  logic [31:0]           wb_dat_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    output cmd_ready_o,
    output rsp_valid_o, rsp_dat_o, rsp_status_o,
    input  rsp_ready_i,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    input  wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i, wb_dat_i
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    input  cmd_ready_o,
    input  rsp_valid_o, rsp_dat_o, rsp_status_o,
    output rsp_ready_i,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    output wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i, wb_dat_i
  );
endinterface

// File: rtl/wb_cmd_initiator.sv
// Single-outstanding Wishbone pipelined initiator: turns one command into one bus
// cycle with retry and timeout handling, then returns a status/data response.
module wb_cmd_initiator #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned MAX_RETRY  = 3
) (
  input logic                clk_i,
  input logic                rst_i,
  wb_cmd_initiator_if.master bus
);

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned SEL_WIDTH  = 4;
  localparam int unsigned TO_WIDTH   = 16;
  localparam int unsigned RTY_WIDTH  = 4;

  localparam logic [TO_WIDTH-1:0]  TO_LAST = TO_WIDTH'(TIMEOUT - 1);
  localparam logic [RTY_WIDTH-1:0] RTY_MAX = RTY_WIDTH'(MAX_RETRY);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_BUS_ERR = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_RTY_EXH = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_RETRY = 3'd3,
    S_RSP   = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [DATA_WIDTH-1:0]   dat_q, dat_d;
  logic [SEL_WIDTH-1:0]    sel_q, sel_d;
  logic [DATA_WIDTH-1:0]   rsp_dat_q, rsp_dat_d;
  logic [1:0]              rsp_st_q, rsp_st_d;
  logic [TO_WIDTH-1:0]     to_q, to_d;
  logic [RTY_WIDTH-1:0]    rty_q, rty_d;
  logic                    sample_c;

  // Terminations count in WAIT, or in REQ on the edge the strobe is accepted.
  assign sample_c = (state_q == S_WAIT) || ((state_q == S_REQ) && !bus.wb_stall_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      rsp_dat_q <= '0;
      rsp_st_q  <= ST_OK;
      to_q      <= '0;
      rty_q     <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_st_q  <= rsp_st_d;
      to_q      <= to_d;
      rty_q     <= rty_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    rsp_dat_d = rsp_dat_q;
    rsp_st_d  = rsp_st_q;
    to_d      = to_q;
    rty_d     = rty_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid_i) begin
          we_d    = bus.cmd_we_i;
          adr_d   = bus.cmd_adr_i;
          dat_d   = bus.cmd_dat_i;
          sel_d   = bus.cmd_sel_i;
          to_d    = '0;
          rty_d   = '0;
          state_d = S_REQ;
        end
      end

      S_REQ, S_WAIT: begin
        to_d = to_q + TO_WIDTH'(1);
        // Priority err > rty > ack > timeout.
        if (sample_c && bus.wb_err_i) begin
          rsp_dat_d = '0;
          rsp_st_d  = ST_BUS_ERR;
          state_d   = S_RSP;
        end else if (sample_c && bus.wb_rty_i) begin
          if (rty_q < RTY_MAX) begin
            rty_d   = rty_q + RTY_WIDTH'(1);
            state_d = S_RETRY;
          end else begin
            rsp_dat_d = '0;
            rsp_st_d  = ST_RTY_EXH;
            state_d   = S_RSP;
          end
        end else if (sample_c && bus.wb_ack_i) begin
          rsp_dat_d = we_q ? '0 : bus.wb_dat_i;
          rsp_st_d  = ST_OK;
          state_d   = S_RSP;
        end else if (to_q == TO_LAST) begin
          rsp_dat_d = '0;
          rsp_st_d  = ST_TIMEOUT;
          state_d   = S_RSP;
        end else if (state_q == S_REQ && !bus.wb_stall_i) begin
          state_d = S_WAIT;
        end
      end

      S_RETRY: begin
        to_d    = '0;
        state_d = S_REQ;
      end

      S_RSP: begin
        if (bus.rsp_ready_i) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.cmd_ready_o  = (state_q == S_IDLE) && !rst_i;
  assign bus.wb_cyc_o     = (state_q == S_REQ) || (state_q == S_WAIT);
  assign bus.wb_stb_o     = (state_q == S_REQ);
  assign bus.wb_we_o      = we_q;
  assign bus.wb_adr_o     = adr_q;
  assign bus.wb_dat_o     = dat_q;
  assign bus.wb_sel_o     = sel_q;
  assign bus.rsp_valid_o  = (state_q == S_RSP);
  assign bus.rsp_dat_o    = rsp_dat_q;
  assign bus.rsp_status_o = rsp_st_q;

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Directed bench for wb_cmd_initiator (TIMEOUT=8, MAX_RETRY=3) with a response scoreboard.
module tb_wb_cmd_initiator;

  typedef struct packed {
    logic [31:0] dat;
    logic [1:0]  st;
  } rsp_t;

  bit   clk = 1'b0;
  logic rst;
  int   tests  = 0;
  int   failed = 0;
  rsp_t exp_q[$];

  wb_cmd_initiator_if #(.ADDR_WIDTH(32)) bus ();

  wb_cmd_initiator #(
    .ADDR_WIDTH(32),
    .TIMEOUT   (8),
    .MAX_RETRY (3)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired tests=%0d failed=%0d", tests, failed);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clr_term();
    bus.wb_ack_i = 1'b0;
    bus.wb_err_i = 1'b0;
    bus.wb_rty_i = 1'b0;
  endtask

  // Offer a command in the current cycle; returns in the cycle after acceptance.
  task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input bit want_rsp,
                       input logic [31:0] e_dat, input logic [1:0] e_st);
    chk("cmd_ready_idle", 32'(bus.cmd_ready_o), 32'd1);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = we;
    bus.cmd_adr_i   = adr;
    bus.cmd_dat_i   = dat;
    bus.cmd_sel_i   = sel;
    if (want_rsp) exp_q.push_back('{dat: e_dat, st: e_st});
    tick();
    bus.cmd_valid_i = 1'b0;
    bus.cmd_adr_i   = 32'hFFFF_FFFF;
    bus.cmd_dat_i   = 32'hFFFF_FFFF;
    chk("stb_after_accept", 32'(bus.wb_stb_o), 32'd1);
    chk("cyc_after_accept", 32'(bus.wb_cyc_o), 32'd1);
    chk("cmd_ready_busy", 32'(bus.cmd_ready_o), 32'd0);
    chk("wb_adr", bus.wb_adr_o, adr);
    chk("wb_dat", bus.wb_dat_o, dat);
    chk("wb_sel", 32'(bus.wb_sel_o), 32'(sel));
    chk("wb_we", 32'(bus.wb_we_o), 32'(we));
  endtask

  // Wait for a response, compare it against the scoreboard, optionally stall it.
  task automatic get_rsp(input int hold);
    int   n = 0;
    rsp_t e;
    while (!bus.rsp_valid_o && n < 20) begin
      tick();
      n++;
    end
    chk("rsp_valid_seen", 32'(bus.rsp_valid_o), 32'd1);
    if (exp_q.size() == 0) begin
      chk("rsp_expected", 32'(exp_q.size()), 32'd1);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    chk("rsp_dat", bus.rsp_dat_o, e.dat);
    chk("rsp_status", 32'(bus.rsp_status_o), 32'(e.st));
    for (int i = 0; i < hold; i++) begin
      bus.cmd_valid_i = 1'b1;
      tick();
      chk("hold_valid", 32'(bus.rsp_valid_o), 32'd1);
      chk("hold_dat", bus.rsp_dat_o, e.dat);
      chk("hold_status", 32'(bus.rsp_status_o), 32'(e.st));
      chk("hold_no_accept", 32'(bus.cmd_ready_o), 32'd0);
    end
    bus.cmd_valid_i = 1'b0;
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;
    chk("rsp_done", 32'(bus.rsp_valid_o), 32'd0);
    chk("ready_after_rsp", 32'(bus.cmd_ready_o), 32'd1);
  endtask

  initial begin
    int n;
    rst             = 1'b1;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_we_i    = 1'b0;
    bus.cmd_adr_i   = '0;
    bus.cmd_dat_i   = '0;
    bus.cmd_sel_i   = '0;
    bus.rsp_ready_i = 1'b0;
    bus.wb_stall_i  = 1'b0;
    bus.wb_dat_i    = '0;
    clr_term();

    // Reset state
    tick();
    tick();
    chk("rst_cyc", 32'(bus.wb_cyc_o), 32'd0);
    chk("rst_stb", 32'(bus.wb_stb_o), 32'd0);
    chk("rst_we", 32'(bus.wb_we_o), 32'd0);
    chk("rst_adr", bus.wb_adr_o, 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("rst_rsp_status", 32'(bus.rsp_status_o), 32'd0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready_o), 32'd0);
    rst = 1'b0;
    #1;
    chk("cmd_ready_after_rst", 32'(bus.cmd_ready_o), 32'd1);

    // Read, ack two cycles after accept
    issue(1'b0, 32'h0000_0100, 32'h0, 4'hF, 1'b1, 32'hDEAD_BEEF, 2'b00);
    tick();
    chk("read_stb_one_cycle", 32'(bus.wb_stb_o), 32'd0);
    chk("read_cyc_wait", 32'(bus.wb_cyc_o), 32'd1);
    bus.wb_ack_i = 1'b1;
    bus.wb_dat_i = 32'hDEAD_BEEF;
    tick();
    clr_term();
    bus.wb_dat_i = 32'h0;
    chk("read_rsp_latency", 32'(bus.rsp_valid_o), 32'd1);
    chk("read_cyc_drop", 32'(bus.wb_cyc_o), 32'd0);
    get_rsp(0);

    // Write with 3 stall cycles, ack on the cycle stall drops
    bus.wb_stall_i = 1'b1;
    issue(1'b1, 32'h0000_0010, 32'h1234_5678, 4'hF, 1'b1, 32'h0, 2'b00);
    for (int i = 0; i < 3; i++) begin
      chk("stall_stb", 32'(bus.wb_stb_o), 32'd1);
      chk("stall_adr", bus.wb_adr_o, 32'h0000_0010);
      chk("stall_dat", bus.wb_dat_o, 32'h1234_5678);
      chk("stall_we", 32'(bus.wb_we_o), 32'd1);
      tick();
    end
    chk("stall_stb_end", 32'(bus.wb_stb_o), 32'd1);
    bus.wb_stall_i = 1'b0;
    bus.wb_ack_i   = 1'b1;
    bus.wb_dat_i   = 32'hCAFE_F00D;
    tick();
    clr_term();
    chk("write_rsp_latency", 32'(bus.rsp_valid_o), 32'd1);
    get_rsp(0);
    tick();
    chk("write_single_rsp", 32'(bus.rsp_valid_o), 32'd0);

    // Retry exhausted after four rty terminations; an ack in RETRY is ignored
    issue(1'b0, 32'h0000_0020, 32'h0, 4'h3, 1'b1, 32'h0, 2'b11);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.wb_stb_o) n++;
      bus.wb_rty_i = 1'b1;
      tick();
      clr_term();
      if (i < 3) begin
        chk("retry_gap_cyc", 32'(bus.wb_cyc_o), 32'd0);
        chk("retry_gap_stb", 32'(bus.wb_stb_o), 32'd0);
        if (i == 0) bus.wb_ack_i = 1'b1;
        tick();
        clr_term();
        chk("retry_restb_adr", bus.wb_adr_o, 32'h0000_0020);
      end
    end
    chk("retry_strobes", 32'(n), 32'd4);
    chk("retry_rsp_latency", 32'(bus.rsp_valid_o), 32'd1);
    get_rsp(0);

    // Timeout: cyc high exactly TIMEOUT cycles, late ack in IDLE ignored
    issue(1'b1, 32'h0000_0030, 32'h5555_AAAA, 4'h1, 1'b1, 32'h0, 2'b10);
    n = 0;
    while (bus.wb_cyc_o && n < 20) begin
      n++;
      tick();
    end
    chk("timeout_cyc_cycles", 32'(n), 32'd8);
    get_rsp(0);
    bus.wb_ack_i = 1'b1;
    tick();
    clr_term();
    chk("late_ack_no_rsp", 32'(bus.rsp_valid_o), 32'd0);
    chk("late_ack_no_cyc", 32'(bus.wb_cyc_o), 32'd0);
    chk("late_ack_idle", 32'(bus.cmd_ready_o), 32'd1);

    // Ack on the timeout cycle wins over the timeout
    issue(1'b0, 32'h0000_0040, 32'h0, 4'hF, 1'b1, 32'hA5A5_A5A5, 2'b00);
    for (int i = 0; i < 7; i++) tick();
    chk("last_cycle_cyc", 32'(bus.wb_cyc_o), 32'd1);
    bus.wb_ack_i = 1'b1;
    bus.wb_dat_i = 32'hA5A5_A5A5;
    tick();
    clr_term();
    get_rsp(0);

    // err and ack together -> bus error; response held 5 cycles
    issue(1'b0, 32'h0000_0050, 32'h0, 4'hF, 1'b1, 32'h0, 2'b01);
    bus.wb_err_i = 1'b1;
    bus.wb_ack_i = 1'b1;
    bus.wb_dat_i = 32'hFFFF_0000;
    tick();
    clr_term();
    get_rsp(5);

    // Reset during WAIT drops the cycle and yields no response
    issue(1'b0, 32'h0000_0060, 32'h0, 4'hF, 1'b0, 32'h0, 2'b00);
    tick();
    chk("wait_cyc", 32'(bus.wb_cyc_o), 32'd1);
    rst = 1'b1;
    tick();
    chk("midrst_cyc", 32'(bus.wb_cyc_o), 32'd0);
    chk("midrst_stb", 32'(bus.wb_stb_o), 32'd0);
    chk("midrst_cmd_ready", 32'(bus.cmd_ready_o), 32'd0);
    chk("midrst_adr", bus.wb_adr_o, 32'd0);
    rst = 1'b0;
    bus.wb_ack_i = 1'b1;
    #1;
    chk("postrst_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      clr_term();
      if (bus.rsp_valid_o) n++;
    end
    chk("postrst_no_rsp", 32'(n), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/wb_cmd_initiator.md
WB_CMD_INITIATOR -- requirements
Module: wb_cmd_initiator

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, giving the Wishbone byte-address width.
REQ-002 SHALL have parameter TIMEOUT, default 255, giving the maximum cycles wb_cyc_o stays high per attempt (range 1..65535).
REQ-003 SHALL have parameter MAX_RETRY, default 3, giving the maximum reissues after wb_rty_i (range 0..15).
REQ-004 SHALL use a single clock and a synchronous, active-high reset; clock and reset are listed first.
REQ-005 clk_i  in  1  sole clock; all state on rising edge.
REQ-006 rst_i  in  1  synchronous active-high reset.
REQ-007 cmd_valid_i  in  1  command offered.
REQ-008 cmd_ready_o  out  1  command accepted when high together with cmd_valid_i.
REQ-009 cmd_we_i  in  1  1 = write, 0 = read.
REQ-010 cmd_adr_i  in  ADDR_WIDTH  byte address.
REQ-011 cmd_dat_i  in  32  write data.
REQ-012 cmd_sel_i  in  4  byte selects.
REQ-013 rsp_valid_o  out  1  response available.
REQ-014 rsp_ready_i  in  1  response consumed when high together with rsp_valid_o.
REQ-015 rsp_dat_o  out  32  read data.
REQ-016 rsp_status_o  out  2  00 ok, 01 bus error, 10 timeout, 11 retry exhausted.
REQ-017 wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone pipelined-mode initiator controls.
REQ-018 wb_adr_o  out  ADDR_WIDTH;  wb_sel_o  out  4;  wb_dat_o  out  32  registered bus fields.
REQ-019 wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i  in  1 each;  wb_dat_i  in  32  responder signals.

Function
REQ-020 SHALL implement FSM states IDLE, REQ, WAIT, RETRY, RSP, with one transaction outstanding at most.
REQ-021 cmd_ready_o SHALL equal (state == IDLE) and not rst_i; a command is captured into registers on the accepting edge, and the FSM goes to REQ.
REQ-022 In REQ, wb_cyc_o = wb_stb_o = 1, and wb_adr_o/wb_sel_o/wb_we_o/wb_dat_o SHALL hold the captured values, stable until the cycle ends.
REQ-023 In REQ with wb_stall_i = 0 at an edge, the strobe is accepted, and the FSM goes to WAIT (wb_stb_o = 0, wb_cyc_o = 1); with wb_stall_i = 1, it stays in REQ.
REQ-024 The termination inputs wb_ack_i/wb_err_i/wb_rty_i SHALL be sampled in WAIT, and also in REQ when wb_stall_i = 0 (same-cycle accept and ack).
REQ-025 Simultaneous terminations SHALL be resolved with priority err > rty > ack.
REQ-026 On ack: wb_cyc_o drops at the next edge; for reads, rsp_dat_o captures wb_dat_i, and for writes it is 0; status 00; the FSM goes to RSP.
REQ-027 On err: cyc drops; rsp_dat_o = 0; status 01; the FSM goes to RSP.
REQ-028 On rty with retry count < MAX_RETRY: the count increments, and the FSM goes to RETRY for exactly one cycle (cyc = stb = 0), then to REQ with the same fields.
REQ-029 On rty with retry count = MAX_RETRY: status 11, rsp_dat_o = 0, and the FSM goes to RSP.
REQ-030 The timeout counter SHALL clear on entry to REQ from IDLE or RETRY and increment each cycle wb_cyc_o = 1.
REQ-031 When the timeout counter reaches TIMEOUT with no termination sampled: cyc/stb drop, status 10, rsp_dat_o = 0, and the FSM goes to RSP.
REQ-032 A termination sampled on the timeout cycle SHALL take precedence over the timeout.
REQ-033 In RSP, rsp_valid_o = 1, with rsp_dat_o/rsp_status_o stable until rsp_ready_i = 1 at an edge; the FSM then goes to IDLE.
REQ-034 A new command SHALL be accepted no earlier than the cycle after the response handshake.
REQ-035 Latency: command accepted at edge N gives wb_stb_o high in cycle N+1; termination sampled at edge M gives rsp_valid_o high in cycle M+1.
REQ-036 Termination inputs arriving in IDLE, RETRY or RSP SHALL be ignored.
REQ-037 The retry count SHALL clear on command acceptance.

Reset
REQ-038 rst_i high at an edge SHALL force IDLE, regardless of state, including mid-cycle.
REQ-039 rst_i high at an edge SHALL force wb_cyc_o = wb_stb_o = wb_we_o = 0, wb_adr_o/wb_sel_o/wb_dat_o = 0, rsp_valid_o = 0, rsp_dat_o = 0, rsp_status_o = 00, and timeout and retry counters = 0.
REQ-040 While rst_i = 1, cmd_ready_o SHALL be 0; after release it is 1 in the first cycle.
REQ-041 A transaction interrupted by reset SHALL produce no response.

Verification
REQ-042 Read, responder acks 2 cycles after accept, wb_dat_i = 0xDEADBEEF -> stb high one cycle, rsp_valid_o one cycle after ack, rsp_dat_o = 0xDEADBEEF, status 00.
REQ-043 Write adr 0x10, dat 0x12345678, sel 0xF, stall held 3 cycles, ack in same cycle stall drops -> fields stable across stall, single response, status 00, rsp_dat_o = 0.
REQ-044 MAX_RETRY = 3, responder asserts rty 4 times -> 4 strobes, each separated by one cycle with cyc low; final status 11.
REQ-045 TIMEOUT = 8, no termination -> cyc high exactly 8 cycles, then status 10; a late ack in IDLE is ignored.
REQ-046 err and ack asserted together -> status 01; rsp_ready_i held low 5 cycles -> response held stable, no new command accepted.
REQ-047 rst_i pulsed while in WAIT -> cyc/stb low after the edge, no rsp_valid_o, cmd_ready_o = 1 the cycle after rst_i falls.
